// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid data port,
// formats store lanes, extracts load data and registers the MEM_WB result.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no load outstanding; may issue a request for the current op
// WAIT_R | load granted, waiting for rvalid; upstream held by stall
module mem_stage (
   input  logic        clk_i_MEM,
   input  logic        rst_i_MEM,
   input  logic        valid_i_MEM,
   input  logic [3:0]  memOp_i_MEM,
   input  logic [31:0] Wt_Data_i_MEM,
   input  logic [4:0]  Wt_Addr_i_MEM,
   input  logic        Wt_Enable_i_MEM,
   input  logic [31:0] Rd_Data2_i_MEM,
   output logic        dmem_req_o_MEM,
   output logic        dmem_we_o_MEM,
   output logic [31:0] dmem_addr_o_MEM,
   output logic [3:0]  dmem_be_o_MEM,
   output logic [31:0] dmem_wdata_o_MEM,
   input  logic        dmem_gnt_i_MEM,
   input  logic        dmem_rvalid_i_MEM,
   input  logic [31:0] dmem_rdata_i_MEM,
   output logic [31:0] Wt_Data_o_MEM,
   output logic [4:0]  Wt_Addr_o_MEM,
   output logic        Wt_Enable_o_MEM,
   output logic        valid_o_MEM,
   output logic        misalign_o_MEM,
   output logic        stall_o_MEM
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_WAIT_R = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic        is_load;
   logic        is_store;
   logic        size_b;
   logic        size_h;
   logic        size_w;
   logic        mem_active;
   logic        misaligned;
   logic        aligned_mem;
   logic [1:0]  lane;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] wb_data_nxt;
   logic        wb_we_nxt;

   assign lane = Wt_Data_i_MEM[1:0];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size_b   = 1'b0;
      size_h   = 1'b0;
      size_w   = 1'b0;
      case (memOp_i_MEM)
         OP_LB, OP_LBU: begin is_load  = 1'b1; size_b = 1'b1; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; size_h = 1'b1; end
         OP_LW:         begin is_load  = 1'b1; size_w = 1'b1; end
         OP_SB:         begin is_store = 1'b1; size_b = 1'b1; end
         OP_SH:         begin is_store = 1'b1; size_h = 1'b1; end
         OP_SW:         begin is_store = 1'b1; size_w = 1'b1; end
         default:       ;
      endcase
   end

   assign mem_active  = valid_i_MEM && (is_load || is_store);
   assign misaligned  = mem_active && ((size_h && lane[0]) || (size_w && (lane != 2'b00)));
   assign aligned_mem = mem_active && !misaligned;

   always_comb begin
      be_c    = 4'b0000;
      wdata_c = 32'h0;
      if (size_b) begin
         be_c    = 4'b0001 << lane;
         wdata_c = {4{Rd_Data2_i_MEM[7:0]}};
      end else if (size_h) begin
         be_c    = lane[1] ? 4'b1100 : 4'b0011;
         wdata_c = {2{Rd_Data2_i_MEM[15:0]}};
      end else if (size_w) begin
         be_c    = 4'b1111;
         wdata_c = Rd_Data2_i_MEM;
      end
   end

   always_comb begin
      case (lane)
         2'd0:    ld_byte = dmem_rdata_i_MEM[7:0];
         2'd1:    ld_byte = dmem_rdata_i_MEM[15:8];
         2'd2:    ld_byte = dmem_rdata_i_MEM[23:16];
         default: ld_byte = dmem_rdata_i_MEM[31:24];
      endcase
      ld_half = lane[1] ? dmem_rdata_i_MEM[31:16] : dmem_rdata_i_MEM[15:0];
   end

   always_comb begin
      case (memOp_i_MEM)
         OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  load_data = {24'h0, ld_byte};
         OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  load_data = {16'h0, ld_half};
         default: load_data = dmem_rdata_i_MEM;
      endcase
   end

   // Request and stall are masked during reset so a held EXE_MEM op cannot leak out.
   always_comb begin
      state_nxt      = state;
      dmem_req_o_MEM = 1'b0;
      stall_o_MEM    = 1'b0;
      if (!rst_i_MEM) begin
         case (state)
            S_IDLE: begin
               dmem_req_o_MEM = aligned_mem;
               stall_o_MEM    = aligned_mem && !(is_store && dmem_gnt_i_MEM);
               if (aligned_mem && is_load && dmem_gnt_i_MEM)
                  state_nxt = S_WAIT_R;
            end
            S_WAIT_R: begin
               stall_o_MEM = !dmem_rvalid_i_MEM;
               if (dmem_rvalid_i_MEM)
                  state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign dmem_we_o_MEM    = dmem_req_o_MEM && is_store;
   assign dmem_addr_o_MEM  = {Wt_Data_i_MEM[31:2], 2'b00};
   assign dmem_be_o_MEM    = be_c;
   assign dmem_wdata_o_MEM = wdata_c;

   assign wb_data_nxt = (aligned_mem && is_load) ? load_data : Wt_Data_i_MEM;
   assign wb_we_nxt   = valid_i_MEM && Wt_Enable_i_MEM && !(mem_active && (is_store || misaligned));

   always_ff @(posedge clk_i_MEM) begin
      if (rst_i_MEM)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // A stalled cycle sends a bubble to WB; data/address keep their last values.
   always_ff @(posedge clk_i_MEM) begin
      if (rst_i_MEM) begin
         Wt_Data_o_MEM   <= 32'h0;
         Wt_Addr_o_MEM   <= 5'd0;
         Wt_Enable_o_MEM <= 1'b0;
         valid_o_MEM     <= 1'b0;
         misalign_o_MEM  <= 1'b0;
      end else if (stall_o_MEM) begin
         Wt_Enable_o_MEM <= 1'b0;
         valid_o_MEM     <= 1'b0;
         misalign_o_MEM  <= 1'b0;
      end else begin
         Wt_Data_o_MEM   <= wb_data_nxt;
         Wt_Addr_o_MEM   <= Wt_Addr_i_MEM;
         Wt_Enable_o_MEM <= wb_we_nxt;
         valid_o_MEM     <= valid_i_MEM;
         misalign_o_MEM  <= misaligned;
      end
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, between the EXE_MEM register and the WB stage; includes its own MEM_WB output register. It consumes the ALU result, destination register and store data produced by EXE, and performs loads and stores over a req/gnt/rvalid data-memory handshake. Non-memory results pass through unchanged. While a memory transaction is outstanding it holds the pipeline with a stall request.

## Interface
Parameters:
- none. Data width is 32 and register address width is 5, from `RegDataBus`/`RegAddrBus` in define.v.

Ports:
- clk_i_MEM  in  1  clock; all state changes on the rising edge.
- rst_i_MEM  in  1  reset, synchronous, active-high (`RstEnable` = 1).
- valid_i_MEM  in  1  EXE_MEM holds a live instruction.
- memOp_i_MEM  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
- Wt_Data_i_MEM  in  32  ALU result; effective address for memory ops.
- Wt_Addr_i_MEM  in  5  destination register.
- Wt_Enable_i_MEM  in  1  register write enable from EXE.
- Rd_Data2_i_MEM  in  32  rs2 value (store data).
- dmem_req_o_MEM  out  1  request valid.
- dmem_we_o_MEM  out  1  1 = store.
- dmem_addr_o_MEM  out  32  {addr[31:2],2'b00}.
- dmem_be_o_MEM  out  4  byte enables.
- dmem_wdata_o_MEM  out  32  lane-replicated store data.
- dmem_gnt_i_MEM  in  1  request accepted this cycle.
- dmem_rvalid_i_MEM  in  1  load data valid.
- dmem_rdata_i_MEM  in  32  load data word.
- Wt_Data_o_MEM  out  32  registered write-back data.
- Wt_Addr_o_MEM  out  5  registered destination.
- Wt_Enable_o_MEM  out  1  registered write enable.
- valid_o_MEM  out  1  registered: the output register holds a retired instruction.
- misalign_o_MEM  out  1  registered: one-cycle misaligned-access flag.
- stall_o_MEM  out  1  combinational: upstream must hold EXE_MEM.

## Operation
- A memory op is active when valid_i_MEM=1 and memOp is 1-8.
- Misaligned access:
  - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - No request is issued and there is no stall.
  - Retires next edge with valid_o=1, Wt_Enable_o=0, misalign_o=1.
- FSM has two states, IDLE and WAIT_R.
  - IDLE, aligned memory op: dmem_req_o=1. Address, we, be and wdata are driven combinationally from the inputs and held stable until gnt.
  - IDLE, store with gnt=1: the store retires this edge; state stays IDLE.
  - IDLE, load with gnt=1: next state WAIT_R.
  - IDLE, gnt=0: stay in IDLE.
  - WAIT_R: dmem_req_o=0.
  - WAIT_R, rvalid=1: the load retires this edge; next state IDLE.
  - rvalid while in IDLE is ignored.
- stall_o_MEM:
  - IDLE: asserted when an aligned memory op is active and not (store and gnt).
  - WAIT_R: asserted when rvalid=0.
- Output register update when not stalled:
  - valid_o ← valid_i.
  - Wt_Addr_o ← Wt_Addr_i.
  - Non-memory op: Wt_Data_o ← Wt_Data_i, Wt_Enable_o ← Wt_Enable_i.
  - Load: Wt_Data_o ← extracted load data, Wt_Enable_o ← Wt_Enable_i.
  - Store: Wt_Data_o ← Wt_Data_i, Wt_Enable_o ← 0.
  - misalign_o ← misaligned condition.
- Output register update when stalled: valid_o=0, Wt_Enable_o=0, misalign_o=0, a bubble into WB. Wt_Data_o and Wt_Addr_o hold their values.
- valid_i=0 forces Wt_Enable_o=0 and valid_o=0 at the next edge.
- Load extraction, with lane = addr[1:0]:
  - LB/LBU: byte rdata[8*lane+7 : 8*lane], sign- or zero-extended to 32.
  - LH/LHU: half rdata[16*addr[1]+15 : 16*addr[1]], sign- or zero-extended.
  - LW: rdata unchanged.
- Store formatting:
  - SB: be=4'b0001<<lane, wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<(2*addr[1]), wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
- Loads to x0 pass Wt_Enable unchanged; RegFile discards writes to x0.

## Timing
- Reset (synchronous, rst_i_MEM=1 at an edge):
  - state=IDLE.
  - Wt_Data_o=0, Wt_Addr_o=0, Wt_Enable_o=0, valid_o=0, misalign_o=0.
  - While reset is high, dmem_req_o=0 and stall_o=0.
- Reset while in WAIT_R abandons the load. A late rvalid arriving after reset is ignored.
- Non-memory op: one-cycle latency, input at edge N appears on outputs after edge N+1. No stall.
- Store with gnt in cycle C: retires at the end of C, zero stall cycles. Each cycle without gnt adds one stall cycle.
- Load with gnt in cycle C and rvalid in cycle C+k (k≥1): stall is high from the first request cycle through C+k-1 and low in C+k. Data is on Wt_Data_o after the C+k edge.
- Back-to-back memory ops are supported. A new request may be issued in the cycle after a retire.
- gnt and rvalid are never used in the same cycle for the same access.

## Test plan
- Reset then pass-through: hold reset 2 cycles; all outputs are 0. Then apply ORI result 0x0000_00FF to x5, we=1: next cycle Wt_Data_o=0xFF, Wt_Addr_o=5, Wt_Enable_o=1, valid_o=1, stall_o=0.
- Store SB, addr 0x103, rs2=0x1234_56AB, gnt immediate: be=4'b1000, wdata=0xABAB_ABAB, addr_o=0x100, we=1, no stall, Wt_Enable_o=0 next cycle.
- Load LB, addr 0x202, rdata=0x0080_0000:
  - gnt after 2 cycles, rvalid 3 cycles later.
  - stall_o stays high for 5 cycles, with bubbles (valid_o=0) meanwhile.
  - Result Wt_Data_o=0xFFFF_FF80.
  - The same access as LBU gives 0x0000_0080.
- Misaligned LW at addr 0x006: dmem_req_o never asserts. Next cycle misalign_o=1, valid_o=1, Wt_Enable_o=0, no stall.
- Reset asserted in WAIT_R, then rvalid=1 one cycle after reset deasserts: outputs stay 0, state is IDLE, no spurious write. A following LW at addr 0x10 with rdata=0xDEAD_BEEF completes normally.
